// File: rtl/covert_field_encoder_if.sv
// Bundle of byte-input, slot-request and field-output signals for the covert field encoder.
// Latency: none (wires only); field_valid follows pkt_req by one cycle inside the encoder.
// Backpressure: data_valid/data_ready handshake on the byte side; pkt_req is never stalled.
interface covert_field_encoder_if #(
  parameter int FIELD_SIZE = 16
);
  logic                  clear;
  logic                  data_valid;
  logic [7:0]            data_in;
  logic                  data_ready;
  logic                  pkt_req;
  logic                  field_valid;
  logic [FIELD_SIZE-1:0] field;
  logic                  byte_done;
  logic [15:0]           bytes_sent;

  // Traffic source / bench side
  modport master (
    output clear, data_valid, data_in, pkt_req,
    input  data_ready, field_valid, field, byte_done, bytes_sent
  );

  // Encoder side
  modport slave (
    input  clear, data_valid, data_in, pkt_req,
    output data_ready, field_valid, field, byte_done, bytes_sent
  );
endinterface

// File: rtl/covert_field_encoder.sv
// Encodes a byte stream MSB-first into a header field: bit 1 repeats the last field, bit 0 emits a fresh LFSR value.
// Latency: field/field_valid registered one cycle after pkt_req; byte_done coincides with the 8th bit's field_valid.
// Backpressure: data_ready is low while a byte is being sent; slots are never refused, idle slots carry fresh values.
module covert_field_encoder #(
  parameter int                    FIELD_SIZE = 16,
  parameter logic [FIELD_SIZE-1:0] LFSR_TAPS  = 16'hB400,
  parameter logic [FIELD_SIZE-1:0] LFSR_SEED  = 16'hACE1
) (
  input logic                   sys_clk,
  input logic                   reset_n,
  covert_field_encoder_if.slave enc
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [FIELD_SIZE-1:0] SEED_EFF =
    (LFSR_SEED == '0) ? {{(FIELD_SIZE-1){1'b0}}, 1'b1} : LFSR_SEED;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q,       state_d;
  logic [FIELD_SIZE-1:0] lfsr_q,        lfsr_d;
  logic [FIELD_SIZE-1:0] field_q,       field_d;
  logic                  field_valid_q, field_valid_d;
  logic                  byte_done_q,   byte_done_d;
  logic [15:0]           bytes_sent_q,  bytes_sent_d;
  logic                  data_ready_q,  data_ready_d;
  logic [3:0]            bit_cnt_q,     bit_cnt_d;
  logic [7:0]            shift_q,       shift_d;

  logic [FIELD_SIZE-1:0] lfsr_step;
  logic                  fresh;

  // Galois step; the field always equals the LFSR state, so a fresh value never equals the current field.
  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);

  // Next-state: byte acceptance, per-slot bit consumption, abort handling and field selection.
  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    field_d       = field_q;
    field_valid_d = enc.pkt_req;
    byte_done_d   = 1'b0;
    bytes_sent_d  = bytes_sent_q;
    data_ready_d  = data_ready_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    fresh         = 1'b1;

    case (state_q)
      IDLE: begin
        data_ready_d = 1'b1;
        if (enc.data_valid && data_ready_q && !enc.clear) begin
          shift_d      = enc.data_in;
          bit_cnt_d    = 4'd8;
          state_d      = SEND;
          data_ready_d = 1'b0;
        end
      end
      SEND: begin
        data_ready_d = 1'b0;
        if (enc.clear) begin
          // Abort wins over everything, including the last bit of a byte.
          state_d      = IDLE;
          bit_cnt_d    = 4'd0;
          data_ready_d = 1'b1;
        end else if (enc.pkt_req) begin
          fresh     = ~shift_q[7];
          shift_d   = {shift_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 4'd1;
          if (bit_cnt_q == 4'd1) begin
            state_d      = IDLE;
            data_ready_d = 1'b1;
            byte_done_d  = 1'b1;
            bytes_sent_d = bytes_sent_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The LFSR only advances when a fresh value goes out.
    if (enc.pkt_req && fresh) begin
      lfsr_d  = lfsr_step;
      field_d = lfsr_step;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      lfsr_q        <= SEED_EFF;
      field_q       <= SEED_EFF;
      field_valid_q <= 1'b0;
      byte_done_q   <= 1'b0;
      bytes_sent_q  <= 16'd0;
      data_ready_q  <= 1'b0;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'd0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      field_q       <= field_d;
      field_valid_q <= field_valid_d;
      byte_done_q   <= byte_done_d;
      bytes_sent_q  <= bytes_sent_d;
      data_ready_q  <= data_ready_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
    end
  end

  assign enc.data_ready  = data_ready_q;
  assign enc.field_valid = field_valid_q;
  assign enc.field       = field_q;
  assign enc.byte_done   = byte_done_q;
  assign enc.bytes_sent  = bytes_sent_q;

endmodule

// File: tb/tb_covert_field_encoder.sv
// Directed bench for covert_field_encoder with a scoreboard of expected field values.
// Latency: expectations are pushed when pkt_req is driven and popped when field_valid is seen.
// Backpressure: bytes are offered only once data_ready is seen high (bounded wait).
module tb_covert_field_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  covert_field_encoder_if #(.FIELD_SIZE(16)) bus ();

  covert_field_encoder #(
    .FIELD_SIZE(16),
    .LFSR_TAPS (16'hB400),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .sys_clk(clk),
    .reset_n(rst_n),
    .enc    (bus)
  );

  typedef struct packed {
    logic [15:0] field;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  logic [15:0] m_field;
  logic [7:0]  m_shift;
  int          m_cnt;
  logic        m_busy;
  logic [15:0] m_sent;

  function automatic logic [15:0] step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_lfsr  = 16'hACE1;
    m_field = 16'hACE1;
    m_shift = 8'h00;
    m_cnt   = 0;
    m_busy  = 1'b0;
    m_sent  = 16'h0000;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.clear = 1'b0; bus.data_valid = 1'b0; bus.data_in = 8'h00; bus.pkt_req = 1'b0;
    tick();
    tick();
    model_reset();
  endtask

  // One packet slot; clr asserts clear in the same cycle.
  task automatic slot(input logic clr);
    logic fresh;
    exp_t e;
    fresh  = 1'b1;
    e.done = 1'b0;
    if (m_busy && !clr) begin
      fresh   = ~m_shift[7];
      m_shift = m_shift << 1;
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        e.done = 1'b1;
        m_sent = m_sent + 16'd1;
      end
    end
    if (clr) begin
      m_busy = 1'b0;
      m_cnt  = 0;
    end
    if (fresh) begin
      m_lfsr  = step(m_lfsr);
      m_field = m_lfsr;
    end
    e.field = m_field;
    exp_q.push_back(e);
    bus.pkt_req = 1'b1;
    bus.clear   = clr;
    tick();
    bus.pkt_req = 1'b0;
    bus.clear   = 1'b0;
  endtask

  task automatic accept(input logic [7:0] b);
    int n;
    n = 0;
    while (bus.data_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", {31'b0, bus.data_ready}, 32'd1);
    bus.data_valid = 1'b1;
    bus.data_in    = b;
    tick();
    bus.data_valid = 1'b0;
    m_busy  = 1'b1;
    m_shift = b;
    m_cnt   = 8;
    check("ready_drop_on_accept", {31'b0, bus.data_ready}, 32'd0);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (bus.field_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_field_valid", {31'b0, bus.field_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("field", {16'b0, bus.field}, {16'b0, e.field});
        check("byte_done", {31'b0, bus.byte_done}, {31'b0, e.done});
      end
    end else if (bus.byte_done === 1'b1) begin
      check("byte_done_without_slot", {31'b0, bus.byte_done}, 32'd0);
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    do_reset();
    // Values held in reset
    check("rst_field", {16'b0, bus.field}, 32'h0000ACE1);
    check("rst_field_valid", {31'b0, bus.field_valid}, 32'd0);
    check("rst_data_ready", {31'b0, bus.data_ready}, 32'd0);
    check("rst_bytes_sent", {16'b0, bus.bytes_sent}, 32'd0);
    check("rst_byte_done", {31'b0, bus.byte_done}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", {31'b0, bus.data_ready}, 32'd1);
    tick();
    check("idle_field", {16'b0, bus.field}, 32'h0000ACE1);
    check("idle_field_valid", {31'b0, bus.field_valid}, 32'd0);

    // 0xA5, back-to-back slots
    accept(8'hA5);
    for (int i = 0; i < 8; i++) slot(1'b0);
    check("a5_last_field", {16'b0, bus.field}, 32'h00001C4E);
    check("a5_byte_done", {31'b0, bus.byte_done}, 32'd1);
    check("a5_ready_with_done", {31'b0, bus.data_ready}, 32'd1);
    check("a5_bytes_sent", {16'b0, bus.bytes_sent}, 32'd1);
    tick();

    // Idle slots decode as zeros
    do_reset();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) slot(1'b0);
    check("idle_slots_field", {16'b0, bus.field}, 32'h0000389C);
    check("idle_slots_bytes_sent", {16'b0, bus.bytes_sent}, 32'd0);
    tick();

    // 0xFF with slots 5 cycles apart
    do_reset();
    rst_n = 1'b1;
    tick();
    accept(8'hFF);
    for (int i = 0; i < 8; i++) begin
      slot(1'b0);
      tick();
      check("gap_field_valid", {31'b0, bus.field_valid}, 32'd0);
      tick();
      tick();
      tick();
    end
    check("ff_field", {16'b0, bus.field}, 32'h0000ACE1);
    check("ff_bytes_sent", {16'b0, bus.bytes_sent}, {16'b0, m_sent});

    // 0x00 aborted by clear after 3 slots
    accept(8'h00);
    for (int i = 0; i < 3; i++) slot(1'b0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    m_busy = 1'b0;
    m_cnt  = 0;
    check("clear_ready", {31'b0, bus.data_ready}, 32'd1);
    slot(1'b0);
    check("clear_bytes_sent", {16'b0, bus.bytes_sent}, {16'b0, m_sent});

    // clear in IDLE blocks acceptance
    bus.clear = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_in = 8'hFF;
    tick();
    bus.clear = 1'b0;
    bus.data_valid = 1'b0;
    check("idle_clear_no_accept", {31'b0, bus.data_ready}, 32'd1);
    slot(1'b0);

    // clear together with the last bit's slot
    accept(8'hFF);
    for (int i = 0; i < 7; i++) slot(1'b0);
    slot(1'b1);
    check("last_bit_clear_count", {16'b0, bus.bytes_sent}, {16'b0, m_sent});
    check("last_bit_clear_ready", {31'b0, bus.data_ready}, 32'd1);
    tick();

    // Counter wrap
    force dut.bytes_sent_q = 16'hFFFF;
    #1;
    release dut.bytes_sent_q;
    m_sent = 16'hFFFF;
    check("preload_bytes_sent", {16'b0, bus.bytes_sent}, 32'h0000FFFF);
    accept(8'h3C);
    for (int i = 0; i < 8; i++) slot(1'b0);
    check("wrap_bytes_sent", {16'b0, bus.bytes_sent}, 32'd0);
    tick();

    // Reset in the middle of a byte
    accept(8'h5A);
    for (int i = 0; i < 3; i++) slot(1'b0);
    do_reset();
    check("midrst_field", {16'b0, bus.field}, 32'h0000ACE1);
    check("midrst_field_valid", {31'b0, bus.field_valid}, 32'd0);
    check("midrst_data_ready", {31'b0, bus.data_ready}, 32'd0);
    check("midrst_bytes_sent", {16'b0, bus.bytes_sent}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("midrst_ready_after", {31'b0, bus.data_ready}, 32'd1);
    slot(1'b0);
    check("midrst_no_partial", {16'b0, bus.field}, 32'h0000E270);
    tick();
    tick();

    check("scoreboard_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
